// File: rtl/song_recorder_pkg.sv
// Shared note-store geometry and recorder types; the song player imports the same widths.
package song_recorder_pkg;
    localparam int KEY_W         = 4;
    localparam int DUR_W         = 8;
    localparam int CNT_W         = 5;
    localparam int MAX_NOTES_DEF = 24;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_NOTE, S_DONE} rec_state_e;

    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic [DUR_W-1:0] dur;
    } note_t;

    function automatic logic [DUR_W-1:0] sat_inc(input logic [DUR_W-1:0] v);
        return (&v) ? v : v + DUR_W'(1);
    endfunction
endpackage

// File: rtl/song_recorder_tick_prescaler.sv
// Free-running clk divider producing a one-cycle tick every TICK_DIV cycles.
module tick_prescaler #(
    parameter int TICK_DIV = 12500000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CW'(TICK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || tick) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/song_recorder.sv
// Records key presses and their durations (in prescaled ticks) into a small note store.
module song_recorder
    import song_recorder_pkg::*;
#(
    parameter int TICK_DIV  = 12500000,
    parameter int MAX_NOTES = MAX_NOTES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rec_en,
    input  logic             key_on,
    input  logic [KEY_W-1:0] key,
    input  logic [CNT_W-1:0] rd_idx,
    output logic [KEY_W-1:0] rd_key,
    output logic [DUR_W-1:0] rd_dur,
    output logic [CNT_W-1:0] note_count,
    output logic             full,
    output logic             recording,
    output logic             done
);
    rec_state_e       state_q, state_d;
    logic [CNT_W-1:0] nc_q, nc_d;
    logic             full_q, full_d;
    logic             done_q, done_d;
    logic [KEY_W-1:0] cur_key_q, cur_key_d;
    logic [DUR_W-1:0] ticks_q, ticks_d;
    logic             key_on_q;
    logic [KEY_W-1:0] key_q;

    logic             tick, clr, onset, wr_en, last;
    logic [DUR_W-1:0] ticks_inc;
    note_t            wr_note;
    note_t            store_q [MAX_NOTES];

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .clk   (clk),
        .rst   (rst),
        .clear (clr),
        .tick  (tick)
    );

    assign onset = key_on && (!key_on_q || key != key_q);
    assign last  = (nc_q == CNT_W'(MAX_NOTES - 1));

    // The tick landing on the closing edge still belongs to the note being closed.
    assign ticks_inc = tick ? sat_inc(ticks_q) : ticks_q;

    always_comb begin
        wr_note.key = cur_key_q;
        wr_note.dur = (ticks_inc == '0) ? DUR_W'(1) : ticks_inc;
    end

    always_comb begin
        state_d   = state_q;
        nc_d      = nc_q;
        full_d    = full_q;
        done_d    = 1'b0;
        cur_key_d = cur_key_q;
        ticks_d   = ticks_q;
        wr_en     = 1'b0;
        clr       = (state_q != S_NOTE);
        case (state_q)
            S_IDLE: begin
                if (rec_en) begin
                    state_d = S_ARMED;
                    nc_d    = '0;
                    full_d  = 1'b0;
                end
            end
            S_ARMED: begin
                if (!rec_en) begin
                    state_d = S_IDLE;
                end else if (onset) begin
                    state_d   = S_NOTE;
                    cur_key_d = key;
                    ticks_d   = '0;
                end
            end
            S_NOTE: begin
                ticks_d = ticks_inc;
                if (!rec_en || onset) begin
                    wr_en = 1'b1;
                    nc_d  = nc_q + CNT_W'(1);
                    // Stop on rec_en fall (wins over a same-cycle onset) or when the store fills.
                    if (!rec_en || last) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        full_d  = last;
                    end else begin
                        cur_key_d = key;
                        ticks_d   = '0;
                        clr       = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (!rec_en) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            nc_q      <= '0;
            full_q    <= 1'b0;
            done_q    <= 1'b0;
            cur_key_q <= '0;
            ticks_q   <= '0;
            key_on_q  <= 1'b0;
            key_q     <= '0;
        end else begin
            state_q   <= state_d;
            nc_q      <= nc_d;
            full_q    <= full_d;
            done_q    <= done_d;
            cur_key_q <= cur_key_d;
            ticks_q   <= ticks_d;
            key_on_q  <= key_on;
            key_q     <= key;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) store_q[nc_q] <= wr_note;
    end

    always_comb begin
        rd_key = '0;
        rd_dur = '0;
        if (rd_idx < nc_q) {rd_key, rd_dur} = store_q[rd_idx];
    end

    assign note_count = nc_q;
    assign full       = full_q;
    assign done       = done_q;
    assign recording  = (state_q == S_ARMED) || (state_q == S_NOTE);
endmodule
